// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: scheduler FSM states, default geometry,
// and the row-address / iteration typedefs used by the scheduler and CNU.
package ldpc_pkg;

  localparam int NUM_ROWS_DEFAULT = 4;
  localparam int ROW_AW_DEFAULT   = $clog2(NUM_ROWS_DEFAULT);
  localparam int CNU_LAT_DEFAULT  = 2;
  localparam int ITER_W_DEFAULT   = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } sched_state_e;

  typedef logic [ROW_AW_DEFAULT-1:0] row_addr_t;
  typedef logic [ITER_W_DEFAULT-1:0] iter_t;

endpackage

// File: rtl/cnu_pipe_tracker.sv
// Tracks rows in flight through the one-cycle memory read and the CNU
// pipeline. Stage 0 is the CNU input cycle (cnu_en); stage CNU_LAT is the
// write-back cycle. A flush empties every stage on the next edge.
module cnu_pipe_tracker
  import ldpc_pkg::*;
#(
  parameter int ROW_AW  = ROW_AW_DEFAULT,
  parameter int CNU_LAT = CNU_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ROW_AW-1:0] in_addr,
  output logic              cnu_en,
  output logic              wr_en,
  output logic [ROW_AW-1:0] wr_addr,
  output logic              empty
);

  logic [CNU_LAT:0]             vld_q;
  logic [CNU_LAT:0]             vld_d;
  logic [CNU_LAT:0][ROW_AW-1:0] addr_q;
  logic [CNU_LAT:0][ROW_AW-1:0] addr_d;
  logic [ROW_AW-1:0]            in_addr_s;

  // Shift valid/address one stage per cycle; idle stages carry a zero address.
  always_comb begin
    vld_d     = vld_q;
    addr_d    = addr_q;
    in_addr_s = {ROW_AW{1'b0}};
    if (in_valid) begin
      in_addr_s = in_addr;
    end else begin
      in_addr_s = {ROW_AW{1'b0}};
    end
    if (flush) begin
      vld_d  = {(CNU_LAT+1){1'b0}};
      addr_d = {((CNU_LAT+1)*ROW_AW){1'b0}};
    end else begin
      vld_d  = {vld_q[CNU_LAT-1:0], in_valid};
      addr_d = {addr_q[CNU_LAT-1:0], in_addr_s};
    end
  end

  // Pipeline stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= {(CNU_LAT+1){1'b0}};
      addr_q <= {((CNU_LAT+1)*ROW_AW){1'b0}};
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

  assign cnu_en  = vld_q[0];
  assign wr_en   = vld_q[CNU_LAT];
  assign wr_addr = addr_q[CNU_LAT];
  // Nothing is left behind the current write-back: no read returning and no
  // row in any CNU stage ahead of the last one.
  assign empty   = ~in_valid & ~(|vld_q[CNU_LAT-1:0]);

endmodule

// File: rtl/cnu_sweep_scheduler.sv
// Sweep scheduler for a single shared CNU. Issues every check row once per
// decoder iteration, tracks rows through read/CNU/write-back, accumulates
// the syndrome and reports done/converged.
// Optional feature macro: CNU_SCHED_EARLY_TERM_EN -- when defined, a sweep
// with zero unsatisfied checks ends the decode before max_iter is reached.
module cnu_sweep_scheduler
  import ldpc_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEFAULT,
  parameter int ROW_AW   = $clog2(NUM_ROWS),
  parameter int CNU_LAT  = CNU_LAT_DEFAULT,
  parameter int ITER_W   = ITER_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] max_iter,
  output logic              rd_en,
  output logic [ROW_AW-1:0] rd_addr,
  output logic              cnu_en,
  input  logic              cnu_p_bit,
  output logic              wr_en,
  output logic [ROW_AW-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(NUM_ROWS - 1);
  localparam logic [ROW_AW-1:0] ROW_ZERO = {ROW_AW{1'b0}};
  localparam logic [ROW_AW-1:0] ROW_ONE  = {{(ROW_AW-1){1'b0}}, 1'b1};
  localparam logic [ITER_W-1:0] IT_ZERO  = {ITER_W{1'b0}};
  localparam logic [ITER_W-1:0] IT_ONE   = {{(ITER_W-1){1'b0}}, 1'b1};
  localparam logic [ITER_W-1:0] IT_MAX   = {ITER_W{1'b1}};

  sched_state_e      state_q, state_d;
  logic [ROW_AW-1:0] row_q, row_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] max_q, max_d;
  logic              unsat_q, unsat_d;
  logic              conv_q, conv_d;
  logic              rd_en_q, rd_en_d;
  logic [ROW_AW-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ITER_W-1:0] iter_inc_s;
  logic [ITER_W-1:0] max_eff_s;
  logic              trk_empty_s;
  logic              cnu_en_s;
  logic              wr_en_s;
  logic [ROW_AW-1:0] wr_addr_s;

  // Row tracker: read strobe in, CNU enable and write-back strobe out.
  cnu_pipe_tracker #(
    .ROW_AW  (ROW_AW),
    .CNU_LAT (CNU_LAT)
  ) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (abort),
    .in_valid (rd_en_q),
    .in_addr  (rd_addr_q),
    .cnu_en   (cnu_en_s),
    .wr_en    (wr_en_s),
    .wr_addr  (wr_addr_s),
    .empty    (trk_empty_s)
  );

  // Saturating iteration increment and effective limit (0 behaves as 1).
  always_comb begin
    iter_inc_s = iter_q;
    max_eff_s  = max_iter;
    if (iter_q == IT_MAX) begin
      iter_inc_s = iter_q;
    end else begin
      iter_inc_s = iter_q + IT_ONE;
    end
    if (max_iter == IT_ZERO) begin
      max_eff_s = IT_ONE;
    end else begin
      max_eff_s = max_iter;
    end
  end

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    iter_d    = iter_q;
    max_d     = max_q;
    conv_d    = conv_q;
    unsat_d   = unsat_q;
    rd_en_d   = 1'b0;
    rd_addr_d = ROW_ZERO;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    // Syndrome accumulates over the write-back cycles of the sweep.
    if (wr_en_s && cnu_p_bit) begin
      unsat_d = 1'b1;
    end else begin
      unsat_d = unsat_q;
    end

    if (abort) begin
      state_d = IDLE;
      row_d   = ROW_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ISSUE;
            row_d   = ROW_ZERO;
            iter_d  = IT_ZERO;
            max_d   = max_eff_s;
            unsat_d = 1'b0;
            conv_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        ISSUE: begin
          rd_en_d   = 1'b1;
          rd_addr_d = row_q;
          if (row_q == LAST_ROW) begin
            row_d   = ROW_ZERO;
            state_d = DRAIN;
          end else begin
            row_d   = row_q + ROW_ONE;
            state_d = ISSUE;
          end
        end
        DRAIN: begin
          // Leave once the final write-back of the sweep is on the bus.
          if (trk_empty_s) begin
            state_d = EVAL;
          end else begin
            state_d = DRAIN;
          end
        end
        EVAL: begin
          iter_d = iter_inc_s;
`ifdef CNU_SCHED_EARLY_TERM_EN
          if (!unsat_q) begin
            state_d = DONE;
            conv_d  = 1'b1;
          end else if (iter_inc_s == max_q) begin
            state_d = DONE;
            conv_d  = 1'b0;
          end else begin
            state_d = ISSUE;
            unsat_d = 1'b0;
          end
`else
          if (iter_inc_s == max_q) begin
            state_d = DONE;
            conv_d  = ~unsat_q;
          end else begin
            state_d = ISSUE;
            unsat_d = 1'b0;
          end
`endif
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Status flags are registered from the next state so they line up with it.
    if ((state_d == ISSUE) || (state_d == DRAIN) || (state_d == EVAL)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
    if (state_d == DONE) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= ROW_ZERO;
      iter_q    <= IT_ZERO;
      max_q     <= IT_ZERO;
      unsat_q   <= 1'b0;
      conv_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= ROW_ZERO;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      row_q     <= row_d;
      iter_q    <= iter_d;
      max_q     <= max_d;
      unsat_q   <= unsat_d;
      conv_q    <= conv_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign cnu_en     = cnu_en_s;
  assign wr_en      = wr_en_s;
  assign wr_addr    = wr_addr_s;
  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = conv_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_cnu_sweep_scheduler.sv
// Bench for cnu_sweep_scheduler (NUM_ROWS=4, CNU_LAT=2, ITER_W=5).
// A table of decode runs is replayed; each cycle is checked against a
// timeline model, write-backs and done pulses against scoreboard queues.
module tb_cnu_sweep_scheduler;
  import ldpc_pkg::*;

  localparam int NR    = 4;
  localparam int LAT   = 2;
  localparam int IW    = 5;
  localparam int AW    = 2;
  // Rows issue on cycles 1..NR, last write-back at NR+LAT+1, EVAL the cycle
  // after, and the next sweep's first read one further cycle on.
  localparam int SWEEP = NR + LAT + 3;
`ifdef CNU_SCHED_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  typedef struct {
    iter_t max_iter;
    int    pmode;       // 0 quiet, 1 row 2 unsatisfied, 2 p_bit high outside wr_en
    int    abort_cyc;   // -1: none
    int    xstart_cyc;  // -1: none; extra start pulse that must be ignored
    int    exp_sweeps;
    logic  exp_conv;
    iter_t exp_iter;
  } vec_t;

  typedef struct { row_addr_t addr; int due; } wr_item_t;
  typedef struct { int cyc; logic conv; iter_t iter; } res_item_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [IW-1:0] max_iter = 5'd0;
  logic          rd_en, cnu_en, wr_en, busy, done, converged;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          cnu_p_bit = 1'b0;
  logic [IW-1:0] iter_count;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int vec_idx = -1;

  wr_item_t  wr_q[$];
  res_item_t res_q[$];
  vec_t      vecs[8];

  cnu_sweep_scheduler #(.NUM_ROWS(NR), .CNU_LAT(LAT), .ITER_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_iter(max_iter),
    .rd_en(rd_en), .rd_addr(rd_addr), .cnu_en(cnu_en), .cnu_p_bit(cnu_p_bit),
    .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done),
    .converged(converged), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d cyc=%0d: got %0d expected %0d", nm, vec_idx, cyc, act, exp);
    end
  endtask

  // Expected strobes for cycle c of a run with S sweeps, optionally aborted.
  task automatic model(input int c, input int s_n, input int ab,
                       output logic e_rd, output int e_ra, output logic e_ce,
                       output logic e_we, output logic e_bz, output logic e_dn);
    e_rd = 1'b0; e_ra = 0; e_ce = 1'b0; e_we = 1'b0;
    e_bz = (c >= 0) && (c < SWEEP * s_n);
    e_dn = (ab < 0) && (c == SWEEP * s_n);
    for (int s = 0; s < s_n; s++) begin
      int b;
      b = SWEEP * s;
      if ((c - b - 1 >= 0) && (c - b - 1 < NR)) begin e_rd = 1'b1; e_ra = c - b - 1; end
      if ((c - b - 2 >= 0) && (c - b - 2 < NR)) e_ce = 1'b1;
      if ((c - b - 2 - LAT >= 0) && (c - b - 2 - LAT < NR)) e_we = 1'b1;
    end
    if ((ab >= 0) && (c > ab)) begin
      e_rd = 1'b0; e_ra = 0; e_ce = 1'b0; e_we = 1'b0; e_bz = 1'b0; e_dn = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic      e_rd, e_ce, e_we, e_bz, e_dn;
    int        e_ra;
    int        last;
    wr_item_t  w;
    res_item_t r;
    @(negedge clk);
    start = 1'b1; max_iter = v.max_iter; cnu_p_bit = 1'b0;
    if (v.abort_cyc < 0) begin
      r.cyc = SWEEP * v.exp_sweeps; r.conv = v.exp_conv; r.iter = v.exp_iter;
      res_q.push_back(r);
    end
    @(negedge clk);
    start = 1'b0;
    max_iter = ~v.max_iter;  // the limit must have been captured with start
    last = SWEEP * v.exp_sweeps + 2;
    for (int c = 0; c <= last; c++) begin
      cyc = c;
      model(c, v.exp_sweeps, v.abort_cyc, e_rd, e_ra, e_ce, e_we, e_bz, e_dn);
      chk("rd_en", int'(rd_en), int'(e_rd));
      if (e_rd) begin
        chk("rd_addr", int'(rd_addr), e_ra);
        w.addr = row_addr_t'(e_ra); w.due = c + 1 + LAT;
        wr_q.push_back(w);
      end
      chk("cnu_en", int'(cnu_en), int'(e_ce));
      chk("wr_en", int'(wr_en), int'(e_we));
      chk("busy", int'(busy), int'(e_bz));
      chk("done", int'(done), int'(e_dn));
      if (wr_en) begin
        chk("wr_expected", int'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          chk("wr_addr", int'(wr_addr), int'(w.addr));
          chk("wr_cycle", c, w.due);
        end
      end
      if (done) begin
        chk("done_expected", int'(res_q.size() > 0), 1);
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          chk("done_cycle", c, r.cyc);
          chk("converged", int'(converged), int'(r.conv));
          chk("iter_count", int'(iter_count), int'(r.iter));
        end
      end
      // Stimulus for the next edge.
      abort = (c == v.abort_cyc);
      if (c == v.abort_cyc) begin
        for (int i = wr_q.size() - 1; i >= 0; i--)
          if (wr_q[i].due > c) wr_q.delete(i);
      end
      start = (c == v.xstart_cyc);
      case (v.pmode)
        1:       cnu_p_bit = wr_en && (wr_addr == 2'd2);
        2:       cnu_p_bit = !wr_en;
        default: cnu_p_bit = 1'b0;
      endcase
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0; cnu_p_bit = 1'b0;
    chk("held_iter", int'(iter_count), int'(v.exp_iter));
    chk("held_conv", int'(converged), int'(v.exp_conv));
    chk("res_q_drained", res_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    res_q.delete();
    wr_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_cnu_en"}, int'(cnu_en), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_conv"}, int'(converged), 0);
    chk({tag, "_iter"}, int'(iter_count), 0);
    chk({tag, "_addrs"}, int'({rd_addr, wr_addr}), 0);
  endtask

  initial begin
    //           max   pm ab  xs  sweeps            conv  iter
    vecs[0] = '{5'd3, 0, -1, -1, ET ? 1 : 3,      1'b1, ET ? 5'd1 : 5'd3};
    vecs[1] = '{5'd3, 1, -1, -1, 3,               1'b0, 5'd3};
    vecs[2] = '{5'd0, 0, -1,  3, 1,               1'b1, 5'd1};
    vecs[3] = '{5'd2, 1, -1, 18, 2,               1'b0, 5'd2};
    vecs[4] = '{5'd3, 0,  5, -1, 3,               1'b0, 5'd0};
    vecs[5] = '{5'd3, 0, -1, -1, ET ? 1 : 3,      1'b1, ET ? 5'd1 : 5'd3};
    vecs[6] = '{5'd2, 2, -1, -1, ET ? 1 : 2,      1'b1, ET ? 5'd1 : 5'd2};
    vecs[7] = '{5'd1, 1, -1, -1, 1,               1'b0, 5'd1};

    // Reset state.
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    for (int i = 0; i < 8; i++) begin
      vec_idx = i;
      run_vec(vecs[i]);
    end

    // start and abort together in IDLE: abort wins.
    vec_idx = 100; cyc = 0;
    @(negedge clk);
    start = 1'b1; abort = 1'b1; max_iter = 5'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", int'(busy), 0);
    @(negedge clk);
    chk("start_abort_rd", int'(rd_en), 0);
    chk("start_abort_busy2", int'(busy), 0);

    // Asynchronous reset in the middle of a sweep.
    vec_idx = 101;
    @(negedge clk);
    start = 1'b1; max_iter = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    cyc = 5;
    chk("midsweep_wr_en", int'(wr_en), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("after_async_reset");

    vec_idx = 102;
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
